core_clk_seq: RTL and testbench
===============================

Name: core_clk_seq

Overview:
- Sequences core start-up and idle clock gating for the core region in pulpino.
- After reset, waits for FLL lock (or a timeout), then releases core fetch on the external fetch-enable.
- Gates the core clock once the core has been idle for a programmable number of cycles, and ungates on a masked interrupt or on loss of the sleep enable.
- Sits between the FLL lock / peripheral config outputs and the core-region fetch_enable_i / clock_gating_i inputs.

Parameters:
- LOCK_TIMEOUT, 1024, cycles to wait for fll_lock_i before proceeding anyway (min 2).
- IDLE_CYCLES, 16, consecutive idle cycles required before gating (min 1).
- WAKE_CYCLES, 2, cycles the clock runs in WAKE before RUN resumes (min 1).
- IRQ_WIDTH, 32, interrupt vector width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, active low
- fetch_enable_i  in  1  external fetch enable (level)
- fll_lock_i  in  1  FLL lock indication
- testmode_i  in  1  test mode; bypasses lock wait, forbids gating
- sleep_en_i  in  1  software permission to gate the core clock
- core_busy_i  in  1  core busy indication
- irq_i  in  IRQ_WIDTH  interrupt lines to core
- irq_mask_i  in  IRQ_WIDTH  wake-up enable per line
- fetch_enable_o  out  1  fetch enable to core region
- clk_en_core_o  out  1  core clock enable (1 = running)
- lock_timeout_o  out  1  sticky: lock wait ended by timeout
- gate_count_o  out  16  number of gating entries, saturating at 16'hFFFF
- state_o  out  3  current state encoding

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values: fetch_enable_o=0, clk_en_core_o=1, lock_timeout_o=0, gate_count_o=0, state_o=LOCK_WAIT. All internal counters are 0.
- State encoding: LOCK_WAIT=0, FETCH_WAIT=1, RUN=2, GATED=3, WAKE=4. Unused codes go to LOCK_WAIT.
- wake = |(irq_i & irq_mask_i).
- idle = !core_busy_i & sleep_en_i & !testmode_i & !wake.
- LOCK_WAIT:
  - lock_cnt increments every cycle.
  - If fll_lock_i or testmode_i: go to FETCH_WAIT.
  - Else if lock_cnt == LOCK_TIMEOUT-1: set lock_timeout_o=1 and go to FETCH_WAIT.
  - Lock has priority over timeout on the same cycle (lock_timeout_o stays 0).
- FETCH_WAIT:
  - fetch_enable_o=0, clk_en_core_o=1.
  - fetch_enable_i=1 → RUN; fetch_enable_o rises on the same edge as state_o becomes 2.
  - Latency from fetch_enable_i to fetch_enable_o is 1 cycle.
- RUN:
  - fetch_enable_o=1, clk_en_core_o=1.
  - idle_cnt increments while idle and clears to 0 on any non-idle cycle.
  - Priority 1: fetch_enable_i=0 → FETCH_WAIT; fetch_enable_o=0 the next cycle; idle_cnt cleared.
  - Priority 2: idle and idle_cnt == IDLE_CYCLES-1 → GATED; clk_en_core_o=0 the next cycle; gate_count_o += 1 (saturating).
  - Gating therefore occurs exactly IDLE_CYCLES cycles after the first idle cycle.
- GATED:
  - clk_en_core_o=0; fetch_enable_o stays 1.
  - Exit to WAKE on any of: wake, !sleep_en_i, testmode_i, core_busy_i, !fetch_enable_i. clk_en_core_o=1 the next cycle.
- WAKE:
  - clk_en_core_o=1; wake_cnt counts up to WAKE_CYCLES-1, then → RUN with idle_cnt=0.
  - Re-gating is not possible inside WAKE.
  - fetch_enable_i low during WAKE is serviced in RUN on the following cycle.
- Loss of fll_lock_i after LOCK_WAIT is ignored.
- Reset mid-operation returns everything to reset values immediately, asynchronously. clk_en_core_o=1 during reset so the core region sees its own reset.
- lock_timeout_o and gate_count_o clear only on reset.

Test Plan:
1. Reset release with fll_lock_i=1 at cycle 3 and fetch_enable_i=1 → state_o 0→1 at cycle 4, fetch_enable_o=1 at cycle 5, lock_timeout_o=0.
2. fll_lock_i held 0, LOCK_TIMEOUT=8 → lock_timeout_o=1 and state_o=1 exactly 8 cycles after reset release. Asserting lock on cycle 8 instead → timeout stays 0.
3. RUN with core_busy_i=0, sleep_en_i=1, IDLE_CYCLES=16 → clk_en_core_o=0 after 16 idle cycles, gate_count_o=1. A single busy pulse at idle cycle 10 restarts the count to a full 16.
4. In GATED, irq_i=32'h0000_0800 with mask 32'h0000_0800 → clk_en_core_o=1 next cycle, state_o 3→4→4→2 with WAKE_CYCLES=2. The same irq with mask 0 → remains gated.
5. fetch_enable_i dropped in the same cycle as gating entry → state_o=1, fetch_enable_o=0, clk_en_core_o stays 1, gate_count_o unchanged.
6. testmode_i=1 throughout → lock wait skipped (state_o=1 one cycle after reset release) and never gated. rst_n pulsed low while GATED → clk_en_core_o=1 and gate_count_o=0 immediately.

Source files
------------

// File: rtl/core_clk_seq_if.sv
// core_clk_seq_if: control and status bundle between the core clock sequencer and its surroundings.
// The slave side is the sequencer and the master side drives the inputs and observes the outputs.
interface core_clk_seq_if #(
  parameter int IRQ_WIDTH = 32
);
  logic                 fetch_enable_i;
  logic                 fll_lock_i;
  logic                 testmode_i;
  logic                 sleep_en_i;
  logic                 core_busy_i;
  logic [IRQ_WIDTH-1:0] irq_i;
  logic [IRQ_WIDTH-1:0] irq_mask_i;
  logic                 fetch_enable_o;
  logic                 clk_en_core_o;
  logic                 lock_timeout_o;
  logic [15:0]          gate_count_o;
  logic [2:0]           state_o;
  modport master (
    output fetch_enable_i, fll_lock_i, testmode_i, sleep_en_i, core_busy_i, irq_i, irq_mask_i,
    input  fetch_enable_o, clk_en_core_o, lock_timeout_o, gate_count_o, state_o
  );
  modport slave (
    input  fetch_enable_i, fll_lock_i, testmode_i, sleep_en_i, core_busy_i, irq_i, irq_mask_i,
    output fetch_enable_o, clk_en_core_o, lock_timeout_o, gate_count_o, state_o
  );
endinterface

// File: rtl/core_clk_seq.sv
// core_clk_seq: sequences core start-up after FLL lock and gates the core clock when it is idle.
// Outputs are registered from the next state, so they change on the same edge as state_o.
module core_clk_seq #(
  parameter int LOCK_TIMEOUT = 1024,
  parameter int IDLE_CYCLES  = 16,
  parameter int WAKE_CYCLES  = 2,
  parameter int IRQ_WIDTH    = 32
) (
  input logic           clk,
  input logic           rst_n,
  core_clk_seq_if.slave bus
);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  typedef enum logic [2:0] {
    LOCK_WAIT  = 3'd0,
    FETCH_WAIT = 3'd1,
    RUN        = 3'd2,
    GATED      = 3'd3,
    WAKE       = 3'd4
  } state_t;
  state_t               r_state, w_nxt;
  logic [LW-1:0]        r_lock_cnt, w_lock_cnt;
  logic [IW-1:0]        r_idle_cnt, w_idle_cnt;
  logic [WW-1:0]        r_wake_cnt, w_wake_cnt;
  logic                 r_fetch_en, r_clk_en, r_lock_to, w_lock_to;
  logic [15:0]          r_gate_cnt, w_gate_cnt;
  logic [IRQ_WIDTH-1:0] w_irq_hit;
  logic                 w_wake, w_idle;
  assign w_irq_hit = bus.irq_i & bus.irq_mask_i;
  assign w_wake    = |w_irq_hit;
  assign w_idle    = !bus.core_busy_i && bus.sleep_en_i && !bus.testmode_i && !w_wake;
  // counters not advanced in the current state fall back to zero
  always_comb begin
    w_nxt      = r_state;
    w_lock_cnt = '0;
    w_idle_cnt = '0;
    w_wake_cnt = '0;
    w_lock_to  = r_lock_to;
    w_gate_cnt = r_gate_cnt;
    case (r_state)
      LOCK_WAIT: begin
        w_lock_cnt = r_lock_cnt + 1'b1;
        if (bus.fll_lock_i || bus.testmode_i) w_nxt = FETCH_WAIT;
        else if (r_lock_cnt == LW'(LOCK_TIMEOUT - 1)) begin
          w_nxt     = FETCH_WAIT;
          w_lock_to = 1'b1;
        end
      end
      FETCH_WAIT: w_nxt = bus.fetch_enable_i ? RUN : FETCH_WAIT;
      RUN: begin
        if (!bus.fetch_enable_i) w_nxt = FETCH_WAIT;
        else if (w_idle && r_idle_cnt == IW'(IDLE_CYCLES - 1)) begin
          w_nxt      = GATED;
          w_gate_cnt = r_gate_cnt + {15'd0, r_gate_cnt != 16'hFFFF};
        end else w_idle_cnt = w_idle ? r_idle_cnt + 1'b1 : '0;
      end
      GATED: w_nxt = (w_wake || !bus.sleep_en_i || bus.testmode_i || bus.core_busy_i || !bus.fetch_enable_i) ? WAKE : GATED;
      WAKE: begin
        if (r_wake_cnt == WW'(WAKE_CYCLES - 1)) w_nxt = RUN;
        else w_wake_cnt = r_wake_cnt + 1'b1;
      end
      default: w_nxt = LOCK_WAIT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOCK_WAIT;
      r_lock_cnt <= '0;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_fetch_en <= 1'b0;
      r_clk_en   <= 1'b1;
      r_lock_to  <= 1'b0;
      r_gate_cnt <= '0;
    end else begin
      r_state    <= w_nxt;
      r_lock_cnt <= w_lock_cnt;
      r_idle_cnt <= w_idle_cnt;
      r_wake_cnt <= w_wake_cnt;
      r_fetch_en <= w_nxt == RUN || w_nxt == GATED || w_nxt == WAKE;
      r_clk_en   <= w_nxt != GATED;
      r_lock_to  <= w_lock_to;
      r_gate_cnt <= w_gate_cnt;
    end
  end
  assign bus.fetch_enable_o = r_fetch_en;
  assign bus.clk_en_core_o  = r_clk_en;
  assign bus.lock_timeout_o = r_lock_to;
  assign bus.gate_count_o   = r_gate_cnt;
  assign bus.state_o        = r_state;
endmodule

// File: tb/tb_core_clk_seq.sv
// tb_core_clk_seq: directed scenarios for the core clock sequencer with hand-computed expectations.
// Observed outputs are packed as {state, fetch_en, clk_en, lock_timeout, gate_count}.
module tb_core_clk_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  core_clk_seq_if #(.IRQ_WIDTH(32)) b();
  core_clk_seq #(
    .LOCK_TIMEOUT(8),
    .IDLE_CYCLES(16),
    .WAKE_CYCLES(2),
    .IRQ_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(b)
  );
  always #5 clk = ~clk;
  function automatic logic [21:0] obs();
    return {b.state_o, b.fetch_enable_o, b.clk_en_core_o, b.lock_timeout_o, b.gate_count_o};
  endfunction
  function automatic logic [21:0] exp_v(input int s, input int fe, input int ce, input int lto, input int gc);
    return {s[2:0], fe[0], ce[0], lto[0], gc[15:0]};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic tm, input logic lock, input logic fe, input logic busy);
    rst_n = 1'b0;
    b.testmode_i = tm;
    b.fll_lock_i = lock;
    b.fetch_enable_i = fe;
    b.core_busy_i = busy;
    b.sleep_en_i = 1'b1;
    b.irq_i = '0;
    b.irq_mask_i = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    do_reset(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs() !== exp_v(0, 0, 1, 0, 0)) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs(), exp_v(0, 0, 1, 0, 0));
    end
  endtask
  task automatic test_startup();
    tick(3);
    checks++;
    if (obs() !== exp_v(0, 0, 1, 0, 0)) begin
      failures++;
      $display("FAIL startup_c3 got=%h exp=%h", obs(), exp_v(0, 0, 1, 0, 0));
    end
    b.fll_lock_i = 1'b1;
    tick(1);
    checks++;
    if (obs() !== exp_v(1, 0, 1, 0, 0)) begin
      failures++;
      $display("FAIL startup_c4 got=%h exp=%h", obs(), exp_v(1, 0, 1, 0, 0));
    end
    tick(1);
    checks++;
    if (obs() !== exp_v(2, 1, 1, 0, 0)) begin
      failures++;
      $display("FAIL startup_c5 got=%h exp=%h", obs(), exp_v(2, 1, 1, 0, 0));
    end
  endtask
  task automatic test_lock_timeout();
    do_reset(1'b0, 1'b0, 1'b0, 1'b1);
    tick(7);
    checks++;
    if (obs() !== exp_v(0, 0, 1, 0, 0)) begin
      failures++;
      $display("FAIL timeout_c7 got=%h exp=%h", obs(), exp_v(0, 0, 1, 0, 0));
    end
    tick(1);
    checks++;
    if (obs() !== exp_v(1, 0, 1, 1, 0)) begin
      failures++;
      $display("FAIL timeout_c8 got=%h exp=%h", obs(), exp_v(1, 0, 1, 1, 0));
    end
    tick(3);
    checks++;
    if (obs() !== exp_v(1, 0, 1, 1, 0)) begin
      failures++;
      $display("FAIL timeout_hold got=%h exp=%h", obs(), exp_v(1, 0, 1, 1, 0));
    end
    do_reset(1'b0, 1'b0, 1'b0, 1'b1);
    tick(7);
    b.fll_lock_i = 1'b1;
    tick(1);
    checks++;
    if (obs() !== exp_v(1, 0, 1, 0, 0)) begin
      failures++;
      $display("FAIL lock_priority got=%h exp=%h", obs(), exp_v(1, 0, 1, 0, 0));
    end
    b.fll_lock_i = 1'b0;
    b.fetch_enable_i = 1'b1;
    tick(1);
    checks++;
    if (obs() !== exp_v(2, 1, 1, 0, 0)) begin
      failures++;
      $display("FAIL lock_loss_ignored got=%h exp=%h", obs(), exp_v(2, 1, 1, 0, 0));
    end
  endtask
  task automatic test_idle_gating();
    b.core_busy_i = 1'b0;
    tick(15);
    checks++;
    if (obs() !== exp_v(2, 1, 1, 0, 0)) begin
      failures++;
      $display("FAIL idle_15 got=%h exp=%h", obs(), exp_v(2, 1, 1, 0, 0));
    end
    tick(1);
    checks++;
    if (obs() !== exp_v(3, 1, 0, 0, 1)) begin
      failures++;
      $display("FAIL idle_16_gate got=%h exp=%h", obs(), exp_v(3, 1, 0, 0, 1));
    end
    b.core_busy_i = 1'b1;
    tick(1);
    checks++;
    if (obs() !== exp_v(4, 1, 1, 0, 1)) begin
      failures++;
      $display("FAIL busy_wake got=%h exp=%h", obs(), exp_v(4, 1, 1, 0, 1));
    end
    tick(2);
    b.core_busy_i = 1'b0;
    tick(9);
    b.core_busy_i = 1'b1;
    tick(1);
    b.core_busy_i = 1'b0;
    tick(15);
    checks++;
    if (obs() !== exp_v(2, 1, 1, 0, 1)) begin
      failures++;
      $display("FAIL restart_15 got=%h exp=%h", obs(), exp_v(2, 1, 1, 0, 1));
    end
    tick(1);
    checks++;
    if (obs() !== exp_v(3, 1, 0, 0, 2)) begin
      failures++;
      $display("FAIL restart_16_gate got=%h exp=%h", obs(), exp_v(3, 1, 0, 0, 2));
    end
  endtask
  task automatic test_irq_wake();
    b.irq_i = 32'h0000_0800;
    b.irq_mask_i = 32'h0;
    tick(3);
    checks++;
    if (obs() !== exp_v(3, 1, 0, 0, 2)) begin
      failures++;
      $display("FAIL irq_masked got=%h exp=%h", obs(), exp_v(3, 1, 0, 0, 2));
    end
    b.irq_mask_i = 32'h0000_0800;
    tick(1);
    checks++;
    if (obs() !== exp_v(4, 1, 1, 0, 2)) begin
      failures++;
      $display("FAIL irq_wake1 got=%h exp=%h", obs(), exp_v(4, 1, 1, 0, 2));
    end
    tick(1);
    checks++;
    if (obs() !== exp_v(4, 1, 1, 0, 2)) begin
      failures++;
      $display("FAIL irq_wake2 got=%h exp=%h", obs(), exp_v(4, 1, 1, 0, 2));
    end
    tick(1);
    checks++;
    if (obs() !== exp_v(2, 1, 1, 0, 2)) begin
      failures++;
      $display("FAIL irq_run got=%h exp=%h", obs(), exp_v(2, 1, 1, 0, 2));
    end
    b.irq_i = '0;
  endtask
  task automatic test_back_to_back();
    tick(15);
    b.fetch_enable_i = 1'b0;
    tick(1);
    checks++;
    if (obs() !== exp_v(1, 0, 1, 0, 2)) begin
      failures++;
      $display("FAIL fetch_drop_at_gate got=%h exp=%h", obs(), exp_v(1, 0, 1, 0, 2));
    end
    tick(2);
    checks++;
    if (obs() !== exp_v(1, 0, 1, 0, 2)) begin
      failures++;
      $display("FAIL fetch_wait_hold got=%h exp=%h", obs(), exp_v(1, 0, 1, 0, 2));
    end
  endtask
  task automatic test_testmode_and_async_reset();
    do_reset(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1);
    checks++;
    if (obs() !== exp_v(1, 0, 1, 0, 0)) begin
      failures++;
      $display("FAIL tm_skip_lock got=%h exp=%h", obs(), exp_v(1, 0, 1, 0, 0));
    end
    tick(21);
    checks++;
    if (obs() !== exp_v(2, 1, 1, 0, 0)) begin
      failures++;
      $display("FAIL tm_no_gate got=%h exp=%h", obs(), exp_v(2, 1, 1, 0, 0));
    end
    b.testmode_i = 1'b0;
    tick(16);
    checks++;
    if (obs() !== exp_v(3, 1, 0, 0, 1)) begin
      failures++;
      $display("FAIL gate_before_rst got=%h exp=%h", obs(), exp_v(3, 1, 0, 0, 1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== exp_v(0, 0, 1, 0, 0)) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs(), exp_v(0, 0, 1, 0, 0));
    end
  endtask
  initial begin
    test_reset();
    test_startup();
    test_lock_timeout();
    test_idle_gating();
    test_irq_wake();
    test_back_to_back();
    test_testmode_and_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
